if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage for the 5-stage pipeline. Owns the PC register, drives a variable-latency instruction-memory request/ack interface, and presents PC_F, Instr_F and PC_Plus4_F to the IF→ID pipeline register. It honours StallF from the hazard unit and branch redirects (PCSrcD/PCBranchD) from ID. While memory is busy it inserts NOP bubbles (32'h0).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hold fetch stage; asserted together with StallD
PCSrcD  in  1  branch/jump taken in ID; redirect to PCBranchD
PCBranchD  in  32  redirect target; bits [1:0] ignored and forced to 0
imem_req  out  1  memory request valid
imem_addr  out  32  request address; stable while imem_req=1 and imem_ack=0
imem_ack  in  1  read data valid; may assert in the same cycle as imem_req (zero-wait)
imem_rdata  in  32  instruction word, valid when imem_ack=1
PC_F  out  32  address of the instruction in Instr_F (or of the outstanding fetch)
Instr_F  out  32  fetched instruction; 0 = bubble
PC_Plus4_F  out  32  PC_F + 4, modulo 2^32
FetchBusyF  out  1  1 when Instr_F is a bubble (waiting on memory)

Behaviour:
- Reset (async, rst_n=0): state=FETCH; PC_F=RESET_PC; PC_Plus4_F=RESET_PC+4; Instr_F=0; FetchBusyF=1; imem_req forced to 0 while rst_n=0. An outstanding request is abandoned; the memory must tolerate this. The first request issues in the first clk cycle after rst_n rises.
- States: FETCH, HOLD, DRAIN. All outputs except imem_req/imem_addr are registered.
- FETCH: imem_req=1; imem_addr=PC_F; Instr_F=0; FetchBusyF=1.
  - ack, and not (PCSrcD & !StallF): Instr_F<=imem_rdata; go to HOLD.
  - ack, and PCSrcD & !StallF: discard the data; PC_F<=PCBranchD; stay in FETCH.
  - no ack, and PCSrcD & !StallF: latch the target in redir_q; go to DRAIN.
  - no ack, otherwise: stay.
- DRAIN: imem_req=1 at the old address; Instr_F=0; further PCSrcD is ignored. On ack, discard the data, PC_F<=redir_q, go to FETCH.
- HOLD: Instr_F is valid; FetchBusyF=0.
  - StallF=1: imem_req=0; all registers hold.
  - StallF=0: next_pc = PCSrcD ? PCBranchD : PC_F+4; imem_req=1; imem_addr=next_pc; PC_F<=next_pc.
    - With ack: Instr_F<=imem_rdata; stay in HOLD.
    - Without ack: Instr_F<=0; go to FETCH.
- Throughput: 1 instruction/cycle with zero-wait memory. Each extra memory wait cycle adds one bubble.
- StallF in FETCH: the request continues because memory cannot cancel it. An ack is captured and the block moves to HOLD, which then holds.
- PCSrcD is acted on only when StallF=0.
- PC arithmetic wraps at 32'hFFFF_FFFC → 32'h0000_0000. PC_F[1:0] is always 0.
- PC_Plus4_F is always registered as the new PC_F + 4.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds output ports perf_fetch_cnt[31:0] (accepted acks whose data is kept) and perf_bubble_cnt[31:0] (cycles with FetchBusyF=1 after reset). Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and logic are absent; core behaviour is identical.

Decomposition:
- Package if_pkg:
  - state enum {FETCH, HOLD, DRAIN}
  - NOP_INSTR = 32'h0
  - INSTR_BYTES = 4
  - default RESET_PC
- Sub-module if_perf_cnt holds the two counters, instantiated only under IF_PERF_CNT_EN. The core needs no further split.

Test Plan:
- Reset with RESET_PC=32'h0040_0000 and zero-wait memory → first cycle after rst_n rises: imem_addr=0x00400000. Then Instr_F follows 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; FetchBusyF=0 from the 2nd cycle.
- Memory acks 2 cycles after request → Instr_F=0 and FetchBusyF=1 for 2 cycles per fetch. With IF_PERF_CNT_EN, perf_bubble_cnt increments by 2 per fetch.
- In HOLD with PC_F=0x100, pulse PCSrcD with PCBranchD=0x203 → imem_addr=0x200 that cycle; next Instr_F is the word at 0x200.
- In FETCH at 0x104 with no ack, assert PCSrcD to 0x300 → DRAIN, address held at 0x104. When ack arrives the data is discarded; next request is at 0x300; the 0x104 word never appears on Instr_F.
- StallF=1 for 3 cycles in HOLD → PC_F, Instr_F and PC_Plus4_F are unchanged and imem_req=0. After release, the fetch resumes at PC_F+4.
- PC_F=32'hFFFF_FFFC → PC_Plus4_F=0 and the next fetch address is 0. Dropping rst_n mid-DRAIN → imem_req=0 immediately and all outputs return to their reset values.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch-stage performance counters: kept fetches and bubble cycles.
// Compiled only when IF_PERF_CNT_EN is defined.
`ifdef IF_PERF_CNT_EN
module if_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc_i,
    input  logic        bubble_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
);

    logic [31:0] fetch_q;
    logic [31:0] bubble_q;

    // Free-running wrapping counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (fetch_inc_i) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (bubble_i) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_q;
    assign bubble_cnt_o = bubble_q;

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake, redirect/stall handling.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt outputs.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_Plus4_F,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt,
`endif
    output logic        FetchBusyF
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] redir_q, redir_d;
    logic        busy_q, busy_d;

    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_s;
    logic        redirect_s;

    assign target_s   = word_align(PCBranchD);
    assign redirect_s = PCSrcD & ~StallF;
    assign next_pc_s  = PCSrcD ? target_s : pc_plus4_q;

    // Next-state and request logic; a request in flight can never be cancelled.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        redir_d    = redir_q;
        busy_d     = busy_q;
        req_s      = 1'b0;
        addr_s     = pc_q;
        case (state_q)
            FETCH: begin
                req_s = 1'b1;
                if (imem_ack) begin
                    if (redirect_s) begin
                        pc_d       = target_s;
                        pc_plus4_d = target_s + INSTR_BYTES;
                    end else begin
                        instr_d = imem_rdata;
                        busy_d  = 1'b0;
                        state_d = HOLD;
                    end
                end else if (redirect_s) begin
                    redir_d = target_s;
                    state_d = DRAIN;
                end else begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                req_s = 1'b1;
                if (imem_ack) begin
                    pc_d       = redir_q;
                    pc_plus4_d = redir_q + INSTR_BYTES;
                    state_d    = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (StallF) begin
                    req_s = 1'b0;
                end else begin
                    req_s      = 1'b1;
                    addr_s     = next_pc_s;
                    pc_d       = next_pc_s;
                    pc_plus4_d = next_pc_s + INSTR_BYTES;
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                    end else begin
                        instr_d = NOP_INSTR;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                instr_d = NOP_INSTR;
                busy_d  = 1'b1;
                state_d = FETCH;
            end
        endcase
    end

    // Stage registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + INSTR_BYTES;
            instr_q    <= NOP_INSTR;
            redir_q    <= RESET_PC;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            redir_q    <= redir_d;
            busy_q     <= busy_d;
        end
    end

    assign imem_req   = req_s & rst_n;
    assign imem_addr  = addr_s;
    assign PC_F       = pc_q;
    assign PC_Plus4_F = pc_plus4_q;
    assign Instr_F    = instr_q;
    assign FetchBusyF = busy_q;

`ifdef IF_PERF_CNT_EN
    logic keep_s;

    assign keep_s = imem_ack & (((state_q == FETCH) & ~redirect_s) |
                                ((state_q == HOLD) & ~StallF));

    if_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_inc_i  (keep_s),
        .bubble_i     (busy_q),
        .fetch_cnt_o  (perf_fetch_cnt),
        .bubble_cnt_o (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed stimulus pushes expected fetch PCs, a monitor pops them.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_F;
    logic [31:0] Instr_F;
    logic [31:0] PC_Plus4_F;
    logic        FetchBusyF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int          tests = 0;
    int          fails = 0;
    int          lat;
    int          wait_cnt;
    bit          ack_block;
    bit          busy_prev = 1'b1;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PC_F       (PC_F),
        .Instr_F    (Instr_F),
        .PC_Plus4_F (PC_Plus4_F),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .FetchBusyF (FetchBusyF)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
    endfunction

    // Memory model: acks once a request has waited lat cycles, unless blocked.
    assign imem_ack   = imem_req && !ack_block && (wait_cnt >= lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", PC_F, RST_PC);
        chk("rst_pc4", PC_Plus4_F, RST_PC + 32'd4);
        chk("rst_instr", Instr_F, 32'h0);
        chk("rst_busy", {31'd0, FetchBusyF}, 32'd1);
    endtask

    // Monitor: a new instruction is presented when leaving FETCH or after an unstalled edge.
    always @(negedge clk) begin
        if (rst_n && !FetchBusyF && (busy_prev || !StallF)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_instr_pc", PC_F, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", PC_F, e);
                chk("sb_instr", Instr_F, mem_word(e));
                chk("sb_pc4", PC_Plus4_F, e + 32'd4);
            end
        end
        busy_prev = FetchBusyF;
    end

    initial begin
        rst_n = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
        lat = 0; ack_block = 1'b0;
        #1 rst_n = 1'b0;
        cyc(); cyc();
        chk_reset();

        // Zero-wait streaming from RESET_PC.
        rst_n = 1'b1;
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        exp_q.push_back(RST_PC + 32'd8);
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        repeat (3) cyc();

        // Stall three cycles in HOLD.
        StallF = 1'b1;
        #1 chk("stall_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", PC_F, RST_PC + 32'd8);
            chk("stall_instr", Instr_F, mem_word(RST_PC + 32'd8));
            chk("stall_pc4", PC_Plus4_F, RST_PC + 32'd12);
            chk("stall_req_hold", {31'd0, imem_req}, 32'd0);
        end
        StallF = 1'b0;
        exp_q.push_back(RST_PC + 32'd12);
        #1 chk("resume_addr", imem_addr, RST_PC + 32'd12);
        cyc();

        // Two-cycle memory latency: two bubbles per fetch.
        lat = 2;
        exp_q.push_back(RST_PC + 32'd16);
        exp_q.push_back(RST_PC + 32'd20);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("lat2_busy", {31'd0, FetchBusyF}, (i % 3 != 2) ? 32'd1 : 32'd0);
            if (i == 0) chk("lat2_bubble", Instr_F, 32'h0);
        end

        // Redirects from HOLD; low target bits are dropped.
        lat = 0; PCSrcD = 1'b1; PCBranchD = 32'h0000_0100;
        exp_q.push_back(32'h0000_0100);
        #1 chk("redir_100", imem_addr, 32'h0000_0100);
        cyc();
        PCBranchD = 32'h0000_0203;
        exp_q.push_back(32'h0000_0200);
        #1 chk("redir_203", imem_addr, 32'h0000_0200);
        cyc();

        // Redirect while a fetch is outstanding goes through DRAIN.
        PCBranchD = 32'h0000_0104; ack_block = 1'b1;
        #1 chk("to_104", imem_addr, 32'h0000_0104);
        cyc();
        PCBranchD = 32'h0000_0300;
        exp_q.push_back(32'h0000_0300);
        #1 chk("fetch_104_addr", imem_addr, 32'h0000_0104);
        cyc();
        PCBranchD = 32'h0000_0500;
        #1;
        chk("drain_addr", imem_addr, 32'h0000_0104);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_busy", {31'd0, FetchBusyF}, 32'd1);
        cyc();
        PCSrcD = 1'b0; ack_block = 1'b0;
        #1 chk("drain_ack_addr", imem_addr, 32'h0000_0104);
        cyc();
        chk("post_drain_addr", imem_addr, 32'h0000_0300);
        chk("post_drain_instr", Instr_F, 32'h0);
        cyc();

        // PC wrap at the top of the address space.
        PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        cyc();
        PCSrcD = 1'b0;
        exp_q.push_back(32'h0000_0000);
        #1;
        chk("wrap_pc", PC_F, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC_Plus4_F, 32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        cyc();

        // Reset dropped in the middle of DRAIN.
        PCSrcD = 1'b1; PCBranchD = 32'h0000_0040; ack_block = 1'b1;
        cyc();
        PCBranchD = 32'h0000_0080;
        cyc();
        PCSrcD = 1'b0;
        #1;
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        chk("pre_rst_addr", imem_addr, 32'h0000_0040);
        rst_n = 1'b0;
        #1 chk_reset();
        cyc();

        // Recover with StallF held: the fetch still completes and then holds.
        ack_block = 1'b0; StallF = 1'b1;
        exp_q.push_back(RST_PC);
        rst_n = 1'b1;
        #1;
        chk("rerst_req", {31'd0, imem_req}, 32'd1);
        chk("rerst_addr", imem_addr, RST_PC);
        repeat (3) cyc();
        chk("end_req", {31'd0, imem_req}, 32'd0);
        chk("end_pc", PC_F, RST_PC);
        chk("end_instr", Instr_F, mem_word(RST_PC));
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
